// File: rtl/bank_pop_reader.sv
// Snapshots a DEPTH x WIDTH register bank plus a word count, then drains the captured
// words in ascending index order over a valid/ready handshake.
module bank_pop_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]   bank_i,
  input  logic [CW-1:0]                 count_i,
  input  logic                          flush_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CW-1:0]                 remaining_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                      state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] snap_q;
  logic [IW-1:0]               idx_q;
  logic [CW-1:0]               rem_q;
  logic [CW-1:0]               eff;

  // Requests beyond the bank size saturate to the whole bank.
  assign eff = (count_i > CW'(DEPTH)) ? CW'(DEPTH) : count_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (load_i) state_d = (eff == '0) ? StDone : StSend;
        StSend: if (pop_i && rem_q == CW'(1)) state_d = StDone;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      snap_q <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
    end else if (flush_i) begin
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_i) begin
            snap_q <= bank_i;
            idx_q  <= '0;
            rem_q  <= eff;
          end
        end
        StSend: begin
          if (pop_i) begin
            rem_q <= rem_q - CW'(1);
            // Index stops at the last slot; the final pop only ends the burst.
            if (rem_q > CW'(1) && idx_q != IW'(DEPTH - 1)) idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_o     = (state_q == StSend);
    busy_o      = (state_q == StSend) || (state_q == StDone);
    done_o      = (state_q == StDone);
    remaining_o = rem_q;
    data_o      = valid_o ? snap_q[idx_q] : '0;
  end

endmodule

// File: tb/tb_bank_pop_reader.sv
// Self-checking bench for bank_pop_reader: directed table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_bank_pop_reader;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic                        load_i;
  logic [DEPTH-1:0][WIDTH-1:0] bank_i;
  logic [CW-1:0]               count_i;
  logic                        flush_i;
  logic                        pop_i;
  logic [WIDTH-1:0]            data_o;
  logic                        valid_o;
  logic                        busy_o;
  logic                        done_o;
  logic [CW-1:0]               remaining_o;

  bank_pop_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_i),
    .bank_i      (bank_i),
    .count_i     (count_i),
    .flush_i     (flush_i),
    .pop_i       (pop_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .remaining_o (remaining_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: words still owed to the consumer, plus a pending done pulse.
  logic [WIDTH-1:0] exp_q[$];
  bit               done_pend = 1'b0;

  logic [WIDTH-1:0] xfers[$];
  int               ndone = 0;

  typedef struct {
    logic             ld;
    logic [CW-1:0]    cnt;
    logic             fl;
    logic             pp;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic [CW-1:0]    er;
    logic             edn;
    logic             eb;
  } vec_t;

  vec_t tbl[6];

  task automatic model_edge();
    int eff;
    if (flush_i) begin
      exp_q.delete();
      done_pend = 1'b0;
    end else if (done_pend) begin
      done_pend = 1'b0;
    end else if (exp_q.size() > 0) begin
      if (pop_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_pend = 1'b1;
      end
    end else if (load_i) begin
      eff = (int'(count_i) > int'(DEPTH)) ? int'(DEPTH) : int'(count_i);
      for (int k = 0; k < eff; k++) exp_q.push_back(bank_i[k]);
      if (eff == 0) done_pend = 1'b1;
    end
  endtask

  task automatic check_model(string nm);
    logic [WIDTH+CW+2:0] act, exp;
    logic             ev;
    ev  = exp_q.size() > 0;
    exp = {ev, ev || done_pend, done_pend, CW'(exp_q.size()), ev ? exp_q[0] : WIDTH'(0)};
    act = {valid_o, busy_o, done_o, remaining_o, data_o};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b b=%0b d=%0b rem=%0d data=%h, want v=%0b b=%0b d=%0b rem=%0d data=%h",
               nm, valid_o, busy_o, done_o, remaining_o, data_o,
               exp[WIDTH+CW+2], exp[WIDTH+CW+1], exp[WIDTH+CW], exp[WIDTH+CW-1:WIDTH],
               exp[WIDTH-1:0]);
    end
  endtask

  task automatic expect_val(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc(string nm);
    if (valid_o && pop_i) xfers.push_back(data_o);
    @(posedge clk_i);
    if (rst_i) model_edge();
    @(negedge clk_i);
    check_model(nm);
    if (done_o) ndone++;
  endtask

  task automatic idle_inputs();
    load_i  = 1'b0;
    flush_i = 1'b0;
    pop_i   = 1'b0;
    count_i = '0;
  endtask

  task automatic fill_bank(int base);
    for (int k = 0; k < DEPTH; k++) bank_i[k] = WIDTH'(base + k);
  endtask

  logic [DEPTH-1:0][WIDTH-1:0] saved;
  bit                          toggle[7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    tbl[0] = '{1'b1, CW'(4), 1'b0, 1'b1, 1'b1, 16'h0100, CW'(4), 1'b0, 1'b1};
    tbl[1] = '{1'b0, CW'(0), 1'b0, 1'b1, 1'b1, 16'h0101, CW'(3), 1'b0, 1'b1};
    tbl[2] = '{1'b0, CW'(0), 1'b0, 1'b1, 1'b1, 16'h0102, CW'(2), 1'b0, 1'b1};
    tbl[3] = '{1'b0, CW'(0), 1'b0, 1'b1, 1'b1, 16'h0103, CW'(1), 1'b0, 1'b1};
    tbl[4] = '{1'b0, CW'(0), 1'b0, 1'b1, 1'b0, 16'h0000, CW'(0), 1'b1, 1'b1};
    tbl[5] = '{1'b0, CW'(0), 1'b0, 1'b1, 1'b0, 16'h0000, CW'(0), 1'b0, 1'b0};

    rst_i = 1'b0;
    idle_inputs();
    fill_bank(16'h100);
    @(negedge clk_i);
    @(negedge clk_i);
    check_model("reset");
    rst_i = 1'b1;
    cyc("idle");

    // Basic drain with pop held high.
    foreach (tbl[i]) begin
      load_i  = tbl[i].ld;
      count_i = tbl[i].cnt;
      flush_i = tbl[i].fl;
      pop_i   = tbl[i].pp;
      cyc("table");
      expect_val($sformatf("row%0d", i),
                 {valid_o, data_o, remaining_o, done_o, busy_o},
                 {tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].edn, tbl[i].eb});
    end

    // Consumer with gaps.
    xfers.delete();
    ndone   = 0;
    load_i  = 1'b1;
    count_i = CW'(4);
    cyc("tog_load");
    load_i = 1'b0;
    foreach (toggle[i]) begin
      pop_i = toggle[i];
      cyc("toggle");
    end
    pop_i = 1'b0;
    cyc("tog_tail");
    cyc("tog_tail");
    expect_val("tog_xfers", xfers.size(), 4);
    for (int k = 0; k < 4 && k < xfers.size(); k++)
      expect_val("tog_word", xfers[k], 32'h100 + k);
    expect_val("tog_done", ndone, 1);

    // Zero-length load.
    load_i  = 1'b1;
    count_i = '0;
    cyc("zero_load");
    load_i = 1'b0;
    expect_val("zero_done", {done_o, valid_o}, 2'b10);
    cyc("zero_idle");
    expect_val("zero_busy", busy_o, 0);

    // Saturating count.
    xfers.delete();
    fill_bank(16'h0a50);
    saved   = bank_i;
    load_i  = 1'b1;
    count_i = CW'(DEPTH + 5);
    pop_i   = 1'b1;
    cyc("sat_load");
    load_i = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) cyc("sat_run");
    expect_val("sat_xfers", xfers.size(), DEPTH);
    if (xfers.size() > 0) expect_val("sat_last", xfers[xfers.size()-1], saved[DEPTH-1]);

    // Load during SEND is ignored; live bank changes do not leak through.
    xfers.delete();
    fill_bank(16'h2000);
    saved   = bank_i;
    load_i  = 1'b1;
    count_i = CW'(5);
    pop_i   = 1'b0;
    cyc("ign_load");
    fill_bank(16'h3000);
    count_i = CW'(2);
    cyc("ign_hold");
    pop_i = 1'b1;
    for (int k = 0; k < 6; k++) cyc("ign_run");
    load_i = 1'b0;
    pop_i  = 1'b0;
    cyc("ign_tail");
    expect_val("ign_xfers", xfers.size(), 5);
    for (int k = 0; k < 5 && k < xfers.size(); k++) expect_val("ign_word", xfers[k], saved[k]);

    // Flush part-way through.
    ndone   = 0;
    load_i  = 1'b1;
    count_i = CW'(5);
    cyc("fl_load");
    load_i = 1'b0;
    pop_i  = 1'b1;
    cyc("fl_pop");
    cyc("fl_pop");
    flush_i = 1'b1;
    cyc("fl_flush");
    flush_i = 1'b0;
    pop_i   = 1'b0;
    expect_val("fl_state", {valid_o, done_o, remaining_o}, '0);
    cyc("fl_after");
    expect_val("fl_nodone", ndone, 0);
    load_i  = 1'b1;
    count_i = CW'(3);
    cyc("fl_reload");
    load_i = 1'b0;
    expect_val("fl_word0", data_o, bank_i[0]);
    flush_i = 1'b1;
    cyc("fl_clear");
    flush_i = 1'b0;

    // Asynchronous reset between edges.
    ndone   = 0;
    load_i  = 1'b1;
    count_i = CW'(5);
    cyc("ar_load");
    load_i = 1'b0;
    cyc("ar_hold");
    #2 rst_i = 1'b0;
    #1;
    exp_q.delete();
    done_pend = 1'b0;
    expect_val("ar_out", {valid_o, busy_o, done_o, remaining_o, data_o}, '0);
    @(negedge clk_i);
    cyc("ar_inrst");
    rst_i = 1'b1;
    xfers.delete();
    load_i  = 1'b1;
    count_i = CW'(3);
    pop_i   = 1'b1;
    cyc("ar_load2");
    load_i = 1'b0;
    for (int k = 0; k < 4; k++) cyc("ar_run");
    expect_val("ar_xfers", xfers.size(), 3);
    expect_val("ar_nodone", ndone, 1);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < DEPTH; k++) bank_i[k] = WIDTH'($urandom);
      load_i  = ($urandom_range(0, 9) < 3);
      count_i = CW'($urandom_range(0, DEPTH + 3));
      flush_i = ($urandom_range(0, 19) == 0);
      pop_i   = ($urandom_range(0, 9) < 6);
      cyc("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_pop_reader.md
# bank_pop_reader

Read-side companion to the team's push-loaded register bank. It captures a snapshot of the DEPTH x WIDTH bank together with the number of valid entries. It then emits those entries one word at a time over a valid/ready handshake, in ascending index order. It sits between the bank and any downstream consumer that drains stored words serially, for example a UART/SPI transmitter or a checker.

## Interface
- WIDTH, 32, bits per word
- DEPTH, 32, number of words in the bank; minimum 2
- CW, $clog2(DEPTH+1), width of count fields (derived, not overridden)

- clk_i  in  1  single clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- load_i  in  1  request to snapshot bank_i/count_i; honoured only in IDLE
- bank_i  in  DEPTH x WIDTH  parallel bank contents; word k is bank_i[k]
- count_i  in  CW  number of valid words to emit, starting at index 0
- flush_i  in  1  synchronous abort; returns to IDLE without a done pulse
- pop_i  in  1  consumer ready; transfer occurs when valid_o && pop_i
- data_o  out  WIDTH  current word; 0 whenever valid_o=0
- valid_o  out  1  data_o holds a word not yet accepted
- busy_o  out  1  high in SEND and DONE
- done_o  out  1  one-cycle pulse after the last word is accepted
- remaining_o  out  CW  words still to be accepted, including the current one

## Operation
- States: IDLE, SEND, DONE. Internal registers: snapshot array, index idx (0..DEPTH-1), remaining counter.
- IDLE: valid_o=0, busy_o=0.
  - load_i=1 captures bank_i into the snapshot and sets eff = min(count_i, DEPTH).
  - If eff=0, go to DONE. Otherwise set idx=0, remaining=eff, and go to SEND.
- SEND: valid_o=1, data_o=snapshot[idx], remaining_o=remaining.
  - On a handshake with remaining>1: idx+1, remaining-1.
  - On a handshake with remaining=1: go to DONE, remaining=0.
  - With pop_i=0: data_o, idx and remaining hold, and valid_o stays high (no retraction).
- DONE: done_o=1, valid_o=0 for exactly one cycle, then IDLE unconditionally.
- load_i outside IDLE is ignored. The snapshot is not disturbed by later changes on bank_i.
- flush_i has priority over load_i and the handshake. In any state, the next state is IDLE with idx=0 and remaining=0, and no done_o is issued.
  - flush_i in IDLE together with load_i: the load is dropped.
- count_i > DEPTH saturates to DEPTH. Index never wraps past DEPTH-1.
- pop_i while valid_o=0 has no effect.

## Timing
- Reset (rst_i=0, asynchronous): state IDLE, data_o=0, valid_o=0, busy_o=0, done_o=0, remaining_o=0, idx=0, snapshot cleared. Release is sampled at the next rising edge.
- Load at edge t: valid_o=1 with word 0 from cycle t+1. Latency is 1 cycle.
- Handshake at edge t: the next word appears on data_o in cycle t+1. With pop_i held high, throughput is 1 word/cycle.
- Last handshake at edge t: done_o=1, valid_o=0 in cycle t+1. The block is in IDLE at t+2, and load_i is accepted at edge t+2 at the earliest.
- Load with eff=0 at edge t: done_o pulses in cycle t+1, and valid_o never rises.
- Reset asserted mid-SEND: outputs are cleared immediately, with no done_o.
- All outputs are registered. There is no combinational path from pop_i or load_i to any output.

## Test plan
- Reset, then load bank[k]=k+0x100 with count_i=4, pop_i held 1:
  - data_o = 0x100, 0x101, 0x102, 0x103 on consecutive cycles.
  - remaining_o goes 4,3,2,1.
  - done_o is high the cycle after 0x103, then busy_o=0.
- Same load with pop_i toggled 1,0,0,1,0,1,1:
  - data_o and remaining_o hold during pop_i=0.
  - Exactly 4 transfers, no duplicates or skips, single done_o pulse.
- count_i=0 load: valid_o stays 0, done_o pulses the cycle after load, back in IDLE next cycle. count_i=DEPTH+5: exactly DEPTH words emitted, last = bank[DEPTH-1].
- Load during SEND with different bank_i/count_i: ignored, original sequence completes. Change bank_i after load: emitted data matches the snapshot, not the live bank.
- flush_i after 2 of 5 words: valid_o=0 next cycle, no done_o, remaining_o=0. A new load then starts again at word 0.
- Assert rst_i=0 asynchronously mid-SEND (between edges): all outputs 0 before the next edge. After release, a load of count 3 behaves normally.
